// File: rtl/time_entry_loader_if.sv
// Keypad/start/cancel inputs and BCD digit/load/status outputs of the entry stage.
// Pure wiring, no storage, so it adds no latency.
// No backpressure: every signal is a level or a single-cycle pulse.
interface time_entry_loader_if;
  // Keypad and control side
  logic       key_valid;
  logic [3:0] key_digit;
  logic       start;
  logic       cancel;
  logic       run_done;
  // Counter chain and status side
  logic [3:0] sec_ones;
  logic [3:0] sec_tens;
  logic [3:0] min_ones;
  logic       load_n;
  logic       load_en;
  logic       running;
  logic       entry_error;

  // Drives the keypad and control inputs and observes the entry stage
  modport master (
    output key_valid, key_digit, start, cancel, run_done,
    input  sec_ones, sec_tens, min_ones, load_n, load_en, running, entry_error
  );

  // The entry stage itself
  modport slave (
    input  key_valid, key_digit, start, cancel, run_done,
    output sec_ones, sec_tens, min_ones, load_n, load_en, running, entry_error
  );
endinterface

// File: rtl/time_entry_loader.sv
// Debounces keypad digits into a 3-digit M:SS entry and issues a 1-cycle parallel load on start.
// Latency: start sampled in ENTRY -> load_n low next cycle -> running high the cycle after.
// No backpressure: keys pressed while running are debounced and dropped, not queued.
module time_entry_loader #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic                 i_clock,
  input  logic                 i_clear,
  time_entry_loader_if.slave   io_ctl
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ENTRY = 2'd1,
    ST_LOAD  = 2'd2,
    ST_RUN   = 2'd3
  } state_t;

  // Value the debounce counter reaches on the last cycle of a qualifying run
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  state_t     r_state;
  state_t     w_state_nxt;

  logic             r_key_held;
  logic [CNT_W-1:0] r_db_cnt;
  logic             w_accept;
  logic             w_is_digit;

  logic [3:0] r_sec_ones;
  logic [3:0] r_sec_tens;
  logic [3:0] r_min_ones;
  logic       w_shift;
  logic       w_clear_digits;

  logic       r_load_n;
  logic       r_load_en;
  logic       r_running;
  logic       r_entry_error;
  logic       w_error_nxt;

  // Debounce: count consecutive cycles of the level opposite to the held/released state;
  // any cycle at the current level restarts the count.
  always_ff @(posedge i_clock or posedge i_clear) begin
    if (i_clear) begin
      r_key_held <= 1'b0;
      r_db_cnt   <= '0;
    end else if (!r_key_held) begin
      if (io_ctl.key_valid) begin
        if (r_db_cnt == DB_LAST) begin
          r_key_held <= 1'b1;
          r_db_cnt   <= '0;
        end else begin
          r_db_cnt <= r_db_cnt + 1'b1;
        end
      end else begin
        r_db_cnt <= '0;
      end
    end else begin
      if (!io_ctl.key_valid) begin
        if (r_db_cnt == DB_LAST) begin
          r_key_held <= 1'b0;
          r_db_cnt   <= '0;
        end else begin
          r_db_cnt <= r_db_cnt + 1'b1;
        end
      end else begin
        r_db_cnt <= '0;
      end
    end
  end

  // Acceptance is the cycle the press run completes; key_digit is taken from that cycle.
  assign w_accept   = !r_key_held && io_ctl.key_valid && (r_db_cnt == DB_LAST);
  assign w_is_digit = (io_ctl.key_digit <= 4'd9);

  // State register
  always_ff @(posedge i_clock or posedge i_clear) begin
    if (i_clear) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and digit-control decisions; cancel overrides everything, then
  // run_done (RUN only), then start (ENTRY only), then a debounced digit.
  always_comb begin
    w_state_nxt    = r_state;
    w_shift        = 1'b0;
    w_clear_digits = 1'b0;
    w_error_nxt    = 1'b0;
    if (io_ctl.cancel) begin
      w_state_nxt    = ST_IDLE;
      w_clear_digits = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // start has no meaning before a digit exists
          if (w_accept && w_is_digit) begin
            w_shift     = 1'b1;
            w_state_nxt = ST_ENTRY;
          end
        end
        ST_ENTRY: begin
          if (io_ctl.start) begin
            // A key accepted alongside start is dropped either way
            if (r_sec_tens <= 4'd5) begin
              w_state_nxt = ST_LOAD;
            end else begin
              w_error_nxt = 1'b1;
            end
          end else if (w_accept && w_is_digit) begin
            w_shift = 1'b1;
          end
        end
        ST_LOAD: begin
          w_state_nxt = ST_RUN;
        end
        ST_RUN: begin
          if (io_ctl.run_done) begin
            w_state_nxt    = ST_IDLE;
            w_clear_digits = 1'b1;
          end
        end
        default: begin
          w_state_nxt    = ST_IDLE;
          w_clear_digits = 1'b1;
        end
      endcase
    end
  end

  // Digit shift register: new digit enters at sec_ones, oldest falls out of min_ones.
  // No digit counter is needed because a fourth digit simply pushes the oldest out.
  always_ff @(posedge i_clock or posedge i_clear) begin
    if (i_clear) begin
      r_sec_ones <= 4'd0;
      r_sec_tens <= 4'd0;
      r_min_ones <= 4'd0;
    end else if (w_clear_digits) begin
      r_sec_ones <= 4'd0;
      r_sec_tens <= 4'd0;
      r_min_ones <= 4'd0;
    end else if (w_shift) begin
      r_min_ones <= r_sec_tens;
      r_sec_tens <= r_sec_ones;
      r_sec_ones <= io_ctl.key_digit;
    end
  end

  // Status outputs registered from the next state so they line up with the state they describe
  always_ff @(posedge i_clock or posedge i_clear) begin
    if (i_clear) begin
      r_load_n      <= 1'b1;
      r_load_en     <= 1'b0;
      r_running     <= 1'b0;
      r_entry_error <= 1'b0;
    end else begin
      r_load_n      <= (w_state_nxt != ST_LOAD);
      r_load_en     <= (w_state_nxt == ST_LOAD);
      r_running     <= (w_state_nxt == ST_RUN);
      r_entry_error <= w_error_nxt;
    end
  end

  assign io_ctl.sec_ones    = r_sec_ones;
  assign io_ctl.sec_tens    = r_sec_tens;
  assign io_ctl.min_ones    = r_min_ones;
  assign io_ctl.load_n      = r_load_n;
  assign io_ctl.load_en     = r_load_en;
  assign io_ctl.running     = r_running;
  assign io_ctl.entry_error = r_entry_error;

endmodule

// File: tb/tb_time_entry_loader.sv
// Directed bench for the keypad entry stage: debounce, digit shift, start/load, errors, cancel and clear.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
// Expected values are hand-computed constants for each step.
module tb_time_entry_loader;

  logic clk   = 1'b0;
  logic clear = 1'b1;
  int   total = 0;
  int   bad   = 0;

  time_entry_loader_if ctl();

  time_entry_loader #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W(8)
  ) dut (
    .i_clock(clk),
    .i_clear(clear),
    .io_ctl(ctl)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_digits(input string tag, input logic [3:0] m, input logic [3:0] t, input logic [3:0] o);
    chk({tag, ".min_ones"}, {4'd0, ctl.min_ones}, {4'd0, m});
    chk({tag, ".sec_tens"}, {4'd0, ctl.sec_tens}, {4'd0, t});
    chk({tag, ".sec_ones"}, {4'd0, ctl.sec_ones}, {4'd0, o});
  endtask

  task automatic press(input logic [3:0] d);
    ctl.key_valid = 1'b1;
    ctl.key_digit = d;
    repeat (6) tick();
    ctl.key_valid = 1'b0;
    repeat (6) tick();
  endtask

  initial begin
    ctl.key_valid = 1'b0;
    ctl.key_digit = 4'd0;
    ctl.start     = 1'b0;
    ctl.cancel    = 1'b0;
    ctl.run_done  = 1'b0;

    // Reset values
    repeat (2) tick();
    chk_digits("reset", 4'd0, 4'd0, 4'd0);
    chk("reset.load_n", {7'd0, ctl.load_n}, 8'd1);
    chk("reset.load_en", {7'd0, ctl.load_en}, 8'd0);
    chk("reset.running", {7'd0, ctl.running}, 8'd0);
    chk("reset.entry_error", {7'd0, ctl.entry_error}, 8'd0);
    clear = 1'b0;
    tick();

    // 1: key held only 3 cycles is never accepted; start in IDLE is ignored
    ctl.key_valid = 1'b1;
    ctl.key_digit = 4'd7;
    repeat (3) tick();
    ctl.key_valid = 1'b0;
    repeat (6) tick();
    chk("short_press.sec_ones", {4'd0, ctl.sec_ones}, 8'd0);
    ctl.start = 1'b1;
    tick();
    ctl.start = 1'b0;
    chk("idle_start.load_n", {7'd0, ctl.load_n}, 8'd1);
    tick();
    chk("idle_start.running", {7'd0, ctl.running}, 8'd0);

    // Glitch: 2 high, 1 low, 2 high never forms a 4-cycle run
    ctl.key_valid = 1'b1;
    ctl.key_digit = 4'd8;
    repeat (2) tick();
    ctl.key_valid = 1'b0;
    tick();
    ctl.key_valid = 1'b1;
    repeat (2) tick();
    ctl.key_valid = 1'b0;
    repeat (6) tick();
    chk("glitch.sec_ones", {4'd0, ctl.sec_ones}, 8'd0);

    // 2: enter 1:30 and start
    press(4'd1);
    chk("first_digit.sec_ones", {4'd0, ctl.sec_ones}, 8'd1);
    press(4'd3);
    press(4'd0);
    chk_digits("entry130", 4'd1, 4'd3, 4'd0);
    ctl.start = 1'b1;
    tick();
    ctl.start = 1'b0;
    chk("load.load_n", {7'd0, ctl.load_n}, 8'd0);
    chk("load.load_en", {7'd0, ctl.load_en}, 8'd1);
    chk("load.running", {7'd0, ctl.running}, 8'd0);
    chk_digits("load", 4'd1, 4'd3, 4'd0);
    tick();
    chk("run.load_n", {7'd0, ctl.load_n}, 8'd1);
    chk("run.load_en", {7'd0, ctl.load_en}, 8'd0);
    chk("run.running", {7'd0, ctl.running}, 8'd1);

    // 5: keys ignored in RUN, then run_done returns to IDLE with digits cleared
    press(4'd5);
    press(4'd8);
    chk_digits("run_keys", 4'd1, 4'd3, 4'd0);
    chk("run_keys.running", {7'd0, ctl.running}, 8'd1);
    ctl.run_done = 1'b1;
    tick();
    ctl.run_done = 1'b0;
    chk("done.running", {7'd0, ctl.running}, 8'd0);
    chk_digits("done", 4'd0, 4'd0, 4'd0);
    ctl.start = 1'b1;
    tick();
    ctl.start = 1'b0;
    chk("done_idle_start.load_n", {7'd0, ctl.load_n}, 8'd1);

    // 3: 2:90 is rejected, stays in ENTRY with digits kept
    press(4'd2);
    press(4'd9);
    press(4'd0);
    chk_digits("entry290", 4'd2, 4'd9, 4'd0);
    ctl.start = 1'b1;
    tick();
    ctl.start = 1'b0;
    chk("reject.entry_error", {7'd0, ctl.entry_error}, 8'd1);
    chk("reject.load_n", {7'd0, ctl.load_n}, 8'd1);
    tick();
    chk("reject_after.entry_error", {7'd0, ctl.entry_error}, 8'd0);
    chk("reject_after.load_n", {7'd0, ctl.load_n}, 8'd1);
    chk_digits("reject_after", 4'd2, 4'd9, 4'd0);
    press(4'd5);
    chk_digits("still_entry", 4'd9, 4'd0, 4'd5);

    // 4: cancel, then four digits drop the oldest; code 12 changes nothing
    ctl.cancel = 1'b1;
    tick();
    ctl.cancel = 1'b0;
    chk_digits("cancel", 4'd0, 4'd0, 4'd0);
    press(4'd1);
    press(4'd2);
    press(4'd3);
    press(4'd4);
    chk_digits("four_digits", 4'd2, 4'd3, 4'd4);
    press(4'd12);
    chk_digits("code12", 4'd2, 4'd3, 4'd4);

    // 6a: clear asserted during LOAD takes effect immediately
    ctl.start = 1'b1;
    tick();
    ctl.start = 1'b0;
    chk("pre_clear.load_n", {7'd0, ctl.load_n}, 8'd0);
    clear = 1'b1;
    #1;
    chk("clear.load_n", {7'd0, ctl.load_n}, 8'd1);
    chk("clear.load_en", {7'd0, ctl.load_en}, 8'd0);
    chk_digits("clear", 4'd0, 4'd0, 4'd0);
    tick();
    clear = 1'b0;
    tick();
    chk("after_clear.running", {7'd0, ctl.running}, 8'd0);

    // 6b: cancel with start in the same cycle wins, no load pulse
    press(4'd1);
    press(4'd0);
    press(4'd0);
    chk_digits("entry100", 4'd1, 4'd0, 4'd0);
    ctl.cancel = 1'b1;
    ctl.start  = 1'b1;
    tick();
    ctl.cancel = 1'b0;
    ctl.start  = 1'b0;
    chk("cancel_start.load_n", {7'd0, ctl.load_n}, 8'd1);
    chk("cancel_start.load_en", {7'd0, ctl.load_en}, 8'd0);
    chk_digits("cancel_start", 4'd0, 4'd0, 4'd0);
    tick();
    chk("cancel_start_after.running", {7'd0, ctl.running}, 8'd0);
    chk("cancel_start_after.load_n", {7'd0, ctl.load_n}, 8'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
